if_fetch_unit: RTL

- Instruction-fetch stage sitting directly upstream of the IF/ID pipeline latch.
- Owns the program counter and issues word fetches to instruction memory over a request/ready handshake with fixed 1-cycle read latency.
- Buffers returned words with their PC+4 in a small fetch queue and presents them to IF/ID.
- Handles branch redirect: queue squash, in-flight response discard, one-cycle flush pulse to IF/ID.

---
 rtl/if_fetch_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit: PC, imem fetch handshake, small fetch queue, branch redirect.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        flush
);

  localparam int AW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CW = AW + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   tag_pc;
  logic          tag_epoch;
  logic          epoch;
  logic          inflight;
  logic [AW:0]   count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   q_ins [FQ_DEPTH];
  logic [31:0]   q_pc  [FQ_DEPTH];

  logic          pop;
  logic          accept;
  logic          enq;
  logic [CW-1:0] occupancy;

  assign valid_out = (count != '0);
  assign pop       = valid_out && !stall && !branch_taken;

  // Occupancy credits the slot freed by this cycle's pop, so a full queue
  // being drained still issues and the stream runs one word per cycle.
  assign occupancy = CW'(count) + CW'(inflight) - CW'(pop);
  assign imem_req  = !rst && !branch_taken && (occupancy < DEPTH_C);
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_ready;

  // A response landing in a redirect cycle belongs to the squashed path.
  assign enq = imem_rvalid && inflight && (tag_epoch == epoch) && !branch_taken;

  assign flush   = branch_taken;
  assign ins_out = valid_out ? q_ins[rd_ptr] : 32'h0;
  assign pc_out  = valid_out ? q_pc[rd_ptr]  : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      tag_pc    <= 32'h0;
      tag_epoch <= 1'b0;
      epoch     <= 1'b0;
      inflight  <= 1'b0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      if (accept) begin
        inflight <= 1'b1;
      end else if (imem_rvalid) begin
        inflight <= 1'b0;
      end

      if (branch_taken) begin
        fetch_pc <= branch_target;
        epoch    <= ~epoch;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (accept) begin
          fetch_pc  <= fetch_pc + PC_STEP;
          tag_pc    <= fetch_pc;
          tag_epoch <= epoch;
        end
        if (enq) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count <= count + (AW+1)'(enq) - (AW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_ins[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]  <= tag_pc + PC_STEP;
    end
  end

  // Read data without an outstanding request is a memory protocol violation.
  assert property (@(posedge clk) disable iff (rst) !(imem_rvalid && !inflight));

endmodule

`default_nettype wire
